spike_decoder: RTL

SPIKE_DECODER -- requirements
Module: spike_decoder

---
 rtl/spike_decoder_pkg.sv | 21 ++
 rtl/spike_decoder_if.sv | 29 ++
 rtl/spike_counter_sat.sv | 23 ++
 rtl/spike_decoder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/spike_decoder_pkg.sv
// Shared types and default sizing for the spike decoder.
// The optional count_out port is controlled by SPIKE_DECODER_COUNT_OUT_EN.
package spike_decoder_pkg;

    localparam int N_CH_DEFAULT   = 8;
    localparam int CNT_W_DEFAULT  = 8;
    localparam int WINDOW_DEFAULT = 100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_ARGMAX,
        ST_DONE
    } state_t;

    // Width needed to index n items; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_decoder_if.sv
// Start/spike/result handshake bundle between the network and the spike decoder.
interface spike_decoder_if
    import spike_decoder_pkg::*;
#(
    parameter int N_CH  = N_CH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
);
    localparam int IDX_W = idx_width(N_CH);

    logic             start;
    logic [N_CH-1:0]  spike_in;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] class_out;
    logic [CNT_W-1:0] max_count;
    logic             no_spike;

    modport master (
        output start, spike_in, out_ready,
        input  busy, out_valid, class_out, max_count, no_spike
    );

    modport slave (
        input  start, spike_in, out_ready,
        output busy, out_valid, class_out, max_count, no_spike
    );

endinterface

// File: rtl/spike_counter_sat.sv
// Per-channel spike counter: synchronous clear, increment, saturates at all-ones.
module spike_counter_sat #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/spike_decoder.sv
// Counts spikes per channel over a fixed window, then picks the busiest channel.
// Defining SPIKE_DECODER_COUNT_OUT_EN exposes the raw counters on count_out.
module spike_decoder
    import spike_decoder_pkg::*;
#(
    parameter int N_CH   = N_CH_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int WINDOW = WINDOW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    spike_decoder_if.slave        bus
`ifdef SPIKE_DECODER_COUNT_OUT_EN
    ,
    output logic [N_CH*CNT_W-1:0] count_out
`endif
);
    localparam int IDX_W = idx_width(N_CH);
    localparam int WIN_W = idx_width(WINDOW);

    state_t           state_reg, state_next;
    logic [WIN_W-1:0] win_cnt_reg;
    logic [IDX_W-1:0] scan_idx_reg;
    logic [IDX_W-1:0] best_idx_reg;
    logic [CNT_W-1:0] best_cnt_reg;
    logic [IDX_W-1:0] class_out_reg;
    logic [CNT_W-1:0] max_count_reg;
    logic             no_spike_reg;

    logic [CNT_W-1:0] cnt [N_CH];
    logic             clear_all;
    logic             window_last;
    logic             scan_last;
    logic             take;
    logic [CNT_W-1:0] scan_cnt;
    logic [CNT_W-1:0] win_cnt;
    logic [IDX_W-1:0] win_idx;

    assign clear_all   = (state_reg == ST_IDLE) && bus.start;
    assign window_last = (win_cnt_reg == WIN_W'(WINDOW - 1));
    assign scan_last   = (scan_idx_reg == IDX_W'(N_CH - 1));
    assign scan_cnt    = cnt[scan_idx_reg];
    // Strict greater-than keeps the lowest index on ties.
    assign take        = (scan_cnt > best_cnt_reg);
    assign win_cnt     = take ? scan_cnt : best_cnt_reg;
    assign win_idx     = take ? scan_idx_reg : best_idx_reg;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            spike_counter_sat #(.CNT_W(CNT_W)) u_cnt (
                .clk     (clk),
                .reset_n (reset_n),
                .clear   (clear_all),
                .inc     ((state_reg == ST_COUNT) && bus.spike_in[gi]),
                .count   (cnt[gi])
            );
`ifdef SPIKE_DECODER_COUNT_OUT_EN
            // Counters only move in COUNT, so this is frozen through ARGMAX/DONE.
            assign count_out[gi*CNT_W +: CNT_W] = cnt[gi];
`endif
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (bus.start)     state_next = ST_COUNT;
            ST_COUNT:  if (window_last)   state_next = ST_ARGMAX;
            ST_ARGMAX: if (scan_last)     state_next = ST_DONE;
            ST_DONE:   if (bus.out_ready) state_next = ST_IDLE;
            default:                      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            win_cnt_reg   <= '0;
            scan_idx_reg  <= '0;
            best_idx_reg  <= '0;
            best_cnt_reg  <= '0;
            class_out_reg <= '0;
            max_count_reg <= '0;
            no_spike_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    win_cnt_reg  <= '0;
                    scan_idx_reg <= '0;
                end
                ST_COUNT: begin
                    win_cnt_reg  <= window_last ? '0 : win_cnt_reg + WIN_W'(1);
                    scan_idx_reg <= '0;
                    best_idx_reg <= '0;
                    best_cnt_reg <= '0;
                end
                ST_ARGMAX: begin
                    scan_idx_reg <= scan_idx_reg + IDX_W'(1);
                    best_idx_reg <= win_idx;
                    best_cnt_reg <= win_cnt;
                    // Result registers change only here, so they hold through DONE and IDLE.
                    if (scan_last) begin
                        class_out_reg <= win_idx;
                        max_count_reg <= win_cnt;
                        no_spike_reg  <= (win_cnt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.out_valid = (state_reg == ST_DONE);
    assign bus.class_out = class_out_reg;
    assign bus.max_count = max_count_reg;
    assign bus.no_spike  = no_spike_reg;

endmodule
